// File: rtl/iic_sinegen_seq.sv
// iic_sinegen_seq
// Sequencer in front of the 16-bit LUT sine generator. It owns the generator
// enable, step and advance strobe, paces reads at a programmable divider rate,
// runs bursts of N samples (or continuously until stopped) and hands each
// captured sample to a downstream consumer over a valid/ready port.
//
// Optional build macro: IIC_SINEGEN_SEQ_OVF_EN
//   When defined, backpressure never stalls the read cadence. A read that
//   lands on an unaccepted sample overwrites it and bumps a saturating 8-bit
//   overflow counter (ovf_cnt_o), which is cleared on each start.
`timescale 1ns/1ps

module iic_sinegen_seq #(
    parameter int DW      = 16,
    parameter int DIV_W   = 8,
    parameter int BURST_W = 12,
    parameter int WARMUP  = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [3:0]         cfg_step_i,
    input  logic [DIV_W-1:0]   cfg_div_i,
    input  logic [BURST_W-1:0] cfg_burst_i,
    input  logic               start_i,
    input  logic               stop_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               sg_en_o,
    output logic [3:0]         sg_step_o,
    output logic               sg_rd_o,
    input  logic [DW-1:0]      sg_data_i,
    output logic [DW-1:0]      smp_data_o,
    output logic               smp_valid_o,
    input  logic               smp_ready_i
`ifdef IIC_SINEGEN_SEQ_OVF_EN
    ,
    output logic [7:0]         ovf_cnt_o
`endif
);

    // Warm-up counter only needs to hold WARMUP-1.
    localparam int WARM_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WARM = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]         state_r;
    logic [1:0]         next_state_s;
    logic               start_s;
    logic               slot_free_s;
    logic               tick_s;
    logic               last_s;

    logic [DIV_W-1:0]   div_cfg_r;
    logic [BURST_W-1:0] burst_cfg_r;
    logic [3:0]         step_r;
    logic [WARM_W-1:0]  warm_cnt_r;
    logic [DIV_W-1:0]   div_cnt_r;
    logic [BURST_W-1:0] burst_cnt_r;

    logic [DW-1:0]      smp_data_r;
    logic               smp_valid_r;
    logic               busy_r;
    logic               done_r;
    logic               sg_en_r;

`ifdef IIC_SINEGEN_SEQ_OVF_EN
    logic [7:0]         ovf_cnt_r;
`endif

    // Read-tick qualification and next-state decode.
    always_comb begin
        next_state_s = state_r;
        start_s      = 1'b0;

`ifdef IIC_SINEGEN_SEQ_OVF_EN
        // Cadence is never held off by the consumer in overflow mode.
        slot_free_s = 1'b1;
`else
        // Output slot can take a new sample if empty or draining this cycle.
        slot_free_s = !smp_valid_r || smp_ready_i;
`endif

        // An abort in the same cycle suppresses the read.
        tick_s = (state_r == ST_RUN) && (div_cnt_r == {DIV_W{1'b0}})
                 && slot_free_s && !stop_i;

        // Nth sample of a finite burst; a zero burst length never ends here.
        last_s = tick_s && (burst_cfg_r != {BURST_W{1'b0}})
                 && (burst_cnt_r == {{(BURST_W-1){1'b0}}, 1'b1});

        case (state_r)
            ST_IDLE: begin
                // Stop wins over a simultaneous start.
                if (start_i && !stop_i) begin
                    next_state_s = ST_WARM;
                    start_s      = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WARM: begin
                if (stop_i) begin
                    next_state_s = ST_DONE;
                end else if (warm_cnt_r == {WARM_W{1'b0}}) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_WARM;
                end
            end
            ST_RUN: begin
                if (stop_i || last_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Configuration snapshot taken only on the IDLE->WARM transition.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_cfg_r   <= {DIV_W{1'b0}};
            burst_cfg_r <= {BURST_W{1'b0}};
            step_r      <= 4'd0;
        end else if (start_s) begin
            div_cfg_r   <= cfg_div_i;
            burst_cfg_r <= cfg_burst_i;
            step_r      <= cfg_step_i;
        end else begin
            div_cfg_r   <= div_cfg_r;
            burst_cfg_r <= burst_cfg_r;
            step_r      <= step_r;
        end
    end

    // Warm-up countdown: generator enabled for WARMUP cycles before the first read.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            warm_cnt_r <= {WARM_W{1'b0}};
        end else if (start_s) begin
            warm_cnt_r <= WARM_W'(WARMUP - 1);
        end else if ((state_r == ST_WARM) && (warm_cnt_r != {WARM_W{1'b0}})) begin
            warm_cnt_r <= warm_cnt_r - {{(WARM_W-1){1'b0}}, 1'b1};
        end else begin
            warm_cnt_r <= warm_cnt_r;
        end
    end

    // Rate divider: zero outside RUN so the first RUN cycle can read at once;
    // parks at zero while the output slot is blocked.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_cnt_r <= {DIV_W{1'b0}};
        end else if (state_r != ST_RUN) begin
            div_cnt_r <= {DIV_W{1'b0}};
        end else if (tick_s) begin
            div_cnt_r <= div_cfg_r;
        end else if (div_cnt_r != {DIV_W{1'b0}}) begin
            div_cnt_r <= div_cnt_r - {{(DIV_W-1){1'b0}}, 1'b1};
        end else begin
            div_cnt_r <= div_cnt_r;
        end
    end

    // Remaining samples in the current burst.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            burst_cnt_r <= {BURST_W{1'b0}};
        end else if (start_s) begin
            burst_cnt_r <= cfg_burst_i;
        end else if (tick_s && (burst_cfg_r != {BURST_W{1'b0}})) begin
            burst_cnt_r <= burst_cnt_r - {{(BURST_W-1){1'b0}}, 1'b1};
        end else begin
            burst_cnt_r <= burst_cnt_r;
        end
    end

    // Output sample holding register; stays stable until accepted, in any state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            smp_data_r  <= {DW{1'b0}};
            smp_valid_r <= 1'b0;
        end else if (tick_s) begin
            smp_data_r  <= sg_data_i;
            smp_valid_r <= 1'b1;
        end else if (smp_valid_r && smp_ready_i) begin
            smp_data_r  <= smp_data_r;
            smp_valid_r <= 1'b0;
        end else begin
            smp_data_r  <= smp_data_r;
            smp_valid_r <= smp_valid_r;
        end
    end

    // Status flags registered from the next state so they align with state_r.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            sg_en_r <= 1'b0;
        end else begin
            busy_r  <= (next_state_s != ST_IDLE);
            done_r  <= (next_state_s == ST_DONE);
            sg_en_r <= (next_state_s == ST_WARM) || (next_state_s == ST_RUN);
        end
    end

`ifdef IIC_SINEGEN_SEQ_OVF_EN
    // Counts reads that overwrote an unaccepted sample; saturates at 255.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf_cnt_r <= 8'd0;
        end else if (start_s) begin
            ovf_cnt_r <= 8'd0;
        end else if (tick_s && smp_valid_r && !smp_ready_i && (ovf_cnt_r != 8'hFF)) begin
            ovf_cnt_r <= ovf_cnt_r + 8'd1;
        end else begin
            ovf_cnt_r <= ovf_cnt_r;
        end
    end

    assign ovf_cnt_o = ovf_cnt_r;
`endif

    // The read strobe is intentionally combinational: ready feeds straight
    // through so a stalled read fires in the very cycle the slot frees.
    assign sg_rd_o     = tick_s;
    assign busy_o      = busy_r;
    assign done_o      = done_r;
    assign sg_en_o     = sg_en_r;
    assign sg_step_o   = step_r;
    assign smp_data_o  = smp_data_r;
    assign smp_valid_o = smp_valid_r;

endmodule

// File: tb/tb_iic_sinegen_seq.sv
// Directed testbench for iic_sinegen_seq. A tiny generator model presents
// 16'h1000 + read index on sg_data_i and advances on every sg_rd_o.
`timescale 1ns/1ps

module tb_iic_sinegen_seq;

    logic        clk;
    logic        rst;
    logic [3:0]  cfg_step;
    logic [7:0]  cfg_div;
    logic [11:0] cfg_burst;
    logic        start;
    logic        stop;
    logic        busy_o;
    logic        done_o;
    logic        sg_en_o;
    logic [3:0]  sg_step_o;
    logic        sg_rd_o;
    logic [15:0] sg_data;
    logic [15:0] smp_data_o;
    logic        smp_valid_o;
    logic        smp_ready;
`ifdef IIC_SINEGEN_SEQ_OVF_EN
    logic [7:0]  ovf_cnt_o;
`endif

    int checks   = 0;
    int failures = 0;

    logic [15:0] gen_idx = 16'd0;
    logic [15:0] acc [0:7];
    int          n_acc;
    int          ticks;

    iic_sinegen_seq dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cfg_step_i  (cfg_step),
        .cfg_div_i   (cfg_div),
        .cfg_burst_i (cfg_burst),
        .start_i     (start),
        .stop_i      (stop),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .sg_en_o     (sg_en_o),
        .sg_step_o   (sg_step_o),
        .sg_rd_o     (sg_rd_o),
        .sg_data_i   (sg_data),
        .smp_data_o  (smp_data_o),
        .smp_valid_o (smp_valid_o),
        .smp_ready_i (smp_ready)
`ifdef IIC_SINEGEN_SEQ_OVF_EN
        ,
        .ovf_cnt_o   (ovf_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Generator model: advance the LUT index on every read strobe.
    always @(posedge clk) begin
        if (sg_rd_o) gen_idx <= gen_idx + 16'd1;
    end
    assign sg_data = 16'h1000 + gen_idx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start with a configuration; returns at the first WARM sample point.
    task automatic launch(input logic [3:0] st, input logic [7:0] dv, input logic [11:0] bl);
        cfg_step  = st;
        cfg_div   = dv;
        cfg_burst = bl;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < max_cyc && !seen; k++) begin
            @(posedge clk); #1;
            if (done_o) seen = 1'b1;
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        rst = 1'b1; cfg_step = 4'd0; cfg_div = 8'd0; cfg_burst = 12'd0;
        start = 1'b0; stop = 1'b0; smp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        // Reset state
        chk("rst_busy",  32'(busy_o),      32'd0);
        chk("rst_done",  32'(done_o),      32'd0);
        chk("rst_en",    32'(sg_en_o),     32'd0);
        chk("rst_rd",    32'(sg_rd_o),     32'd0);
        chk("rst_valid", 32'(smp_valid_o), 32'd0);
        chk("rst_data",  32'(smp_data_o),  32'd0);
        chk("rst_step",  32'(sg_step_o),   32'd0);
        @(posedge clk); #1;

        // 1: div=3 burst=4 step=1, consumer always ready
        launch(4'd1, 8'd3, 12'd4);
        chk("t1_step", 32'(sg_step_o), 32'd1);
        for (int c = 0; c < 18; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            chk("t1_rd",    32'(sg_rd_o),     32'((c == 2) || (c == 6) || (c == 10) || (c == 14)));
            chk("t1_valid", 32'(smp_valid_o), 32'((c == 3) || (c == 7) || (c == 11) || (c == 15)));
            chk("t1_done",  32'(done_o),      32'(c == 15));
            chk("t1_busy",  32'(busy_o),      32'(c <= 15));
            chk("t1_en",    32'(sg_en_o),     32'(c <= 14));
        end
        chk("t1_data", 32'(smp_data_o), 32'h1003);

        // 2: div=0 burst=8, consumer stalls 10 cycles after the first sample
        launch(4'd2, 8'd0, 12'd8);
        n_acc = 0;
        for (int c = 1; c < 80 && n_acc < 8; c++) begin
            @(posedge clk); #1;
            smp_ready = !((c >= 3) && (c <= 12));
            #1;
            if ((c >= 3) && (c <= 12)) begin
                chk("t2_stall_rd",    32'(sg_rd_o),     32'd0);
                chk("t2_stall_data",  32'(smp_data_o),  32'h1004);
                chk("t2_stall_valid", 32'(smp_valid_o), 32'd1);
                chk("t2_stall_en",    32'(sg_en_o),     32'd1);
            end
            if (smp_valid_o && smp_ready) begin
                acc[n_acc] = smp_data_o;
                n_acc++;
            end
        end
        chk("t2_count", 32'(n_acc), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk("t2_order", 32'(acc[i]), 32'h1004 + 32'(i));
        end
        @(posedge clk); #1;
        chk("t2_idle",  32'(busy_o),      32'd0);
        chk("t2_drain", 32'(smp_valid_o), 32'd0);

        // 3: continuous, div=1, abort after the 5th read with a sample held
        smp_ready = 1'b1;
        launch(4'd2, 8'd1, 12'd0);
        ticks = 0;
        for (int c = 0; c < 60 && ticks < 5; c++) begin
            @(posedge clk); #1;
            if (sg_rd_o) ticks++;
        end
        chk("t3_ticks", 32'(ticks), 32'd5);
        @(posedge clk); #1;
        smp_ready = 1'b0;
        stop      = 1'b1;
        #1;
        chk("t3_stop_rd",   32'(sg_rd_o),    32'd0);
        chk("t3_held_data", 32'(smp_data_o), 32'h1010);
        @(posedge clk); #1;
        stop = 1'b0;
        chk("t3_done",     32'(done_o),      32'd1);
        chk("t3_en",       32'(sg_en_o),     32'd0);
        chk("t3_busy",     32'(busy_o),      32'd1);
        chk("t3_rd",       32'(sg_rd_o),     32'd0);
        chk("t3_valid",    32'(smp_valid_o), 32'd1);
        chk("t3_data",     32'(smp_data_o),  32'h1010);
        @(posedge clk); #1;
        chk("t3_done_end", 32'(done_o),      32'd0);
        chk("t3_idle",     32'(busy_o),      32'd0);
        chk("t3_keep",     32'(smp_valid_o), 32'd1);
        smp_ready = 1'b1;
        @(posedge clk); #1;
        chk("t3_accept",   32'(smp_valid_o), 32'd0);
        chk("t3_data2",    32'(smp_data_o),  32'h1010);

        // Start and stop together in IDLE: stop wins
        start = 1'b1; stop = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        chk("ss_busy", 32'(busy_o), 32'd0);

        // 4: restart while busy is ignored, config changes are not picked up
        launch(4'd5, 8'd2, 12'd3);
        chk("t4_step", 32'(sg_step_o), 32'd5);
        cfg_step = 4'd7; cfg_div = 8'd0; cfg_burst = 12'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("t4_step_hold", 32'(sg_step_o), 32'd5);
        chk("t4_busy",      32'(busy_o),    32'd1);
        wait_done("t4_wait", 40);
        chk("t4_step_done", 32'(sg_step_o),  32'd5);
        chk("t4_data",      32'(smp_data_o), 32'h1013);
        @(posedge clk); #1;
        chk("t4_idle",      32'(busy_o),    32'd0);
        launch(4'd7, 8'd0, 12'd0);
        chk("t4_step_new",  32'(sg_step_o), 32'd7);
        @(posedge clk); #1;
        @(posedge clk); #1;
        stop = 1'b1;
        #1;
        chk("t4_supp_rd",   32'(sg_rd_o),     32'd0);
        @(posedge clk); #1;
        stop = 1'b0;
        chk("t4_supp_done", 32'(done_o),      32'd1);
        chk("t4_supp_val",  32'(smp_valid_o), 32'd0);
        chk("t4_supp_data", 32'(smp_data_o),  32'h1013);
        @(posedge clk); #1;

        // 5: async reset mid-RUN with a pending sample, then restart
        smp_ready = 1'b0;
        launch(4'd1, 8'd3, 12'd0);
        repeat (5) begin @(posedge clk); #1; end
        chk("t5_pending", 32'(smp_valid_o), 32'd1);
        chk("t5_pdata",   32'(smp_data_o),  32'h1014);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_busy",  32'(busy_o),      32'd0);
        chk("t5_done",  32'(done_o),      32'd0);
        chk("t5_en",    32'(sg_en_o),     32'd0);
        chk("t5_rd",    32'(sg_rd_o),     32'd0);
        chk("t5_valid", 32'(smp_valid_o), 32'd0);
        chk("t5_data",  32'(smp_data_o),  32'd0);
        chk("t5_step",  32'(sg_step_o),   32'd0);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        smp_ready = 1'b1;
        launch(4'd3, 8'd0, 12'd2);
        wait_done("t5_wait", 30);
        chk("t5_rstep", 32'(sg_step_o),  32'd3);
        chk("t5_rdata", 32'(smp_data_o), 32'h1016);
        @(posedge clk); #1;

`ifdef IIC_SINEGEN_SEQ_OVF_EN
        // 6: overflow mode, consumer never ready
        smp_ready = 1'b0;
        launch(4'd1, 8'd0, 12'd6);
        wait_done("t6_wait", 30);
        chk("t6_ovf",   32'(ovf_cnt_o),   32'd5);
        chk("t6_data",  32'(smp_data_o),  32'h101C);
        chk("t6_valid", 32'(smp_valid_o), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
